// File: rtl/tx_data_source.sv
// Payload bit source for the TX sequencer: 16-byte buffer shifted out MSB first on dataclk rises.
// Optional sticky dataclk-misuse flag enabled by defining TXDATA_OVERRUN_EN.
module tx_data_source (
    input  logic       oscclk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] bitcount,
    input  logic       arm,
    input  logic       abort,
    input  logic       dataclk,
    output logic       databitsrc,
    output logic       datadone,
    output logic       busy
`ifdef TXDATA_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, SEND, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mem [16];
    logic [6:0] ptr;
    logic [7:0] len;
    logic       dclk_sync_p0;
    logic       dclk_sync_p1;
    logic       dclk_prev_p2;
    logic       rise;
    logic       last;
    logic       start;

    function automatic logic [7:0] clamp_len(input logic [7:0] bc);
        return (bc > 8'd128) ? 8'd128 : bc;
    endfunction

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized level for edge detect
    always_ff @(posedge oscclk or negedge reset_n) begin
        if (!reset_n) begin
            dclk_sync_p0 <= 1'b0;
            dclk_sync_p1 <= 1'b0;
            dclk_prev_p2 <= 1'b0;
        end else begin
            dclk_sync_p0 <= dataclk;
            dclk_sync_p1 <= dclk_sync_p0;
            dclk_prev_p2 <= dclk_sync_p1;
        end
    end

    assign rise  = dclk_sync_p1 & ~dclk_prev_p2;
    assign last  = ({1'b0, ptr} == (len - 8'd1));
    assign start = arm & ~abort & (bitcount != 8'd0) & ((state == IDLE) | (state == DONE));

    always_ff @(posedge oscclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)         state_nxt = ARMED;
                ARMED:   if (rise)          state_nxt = SEND;
                SEND:    if (rise && last)  state_nxt = DONE;
                DONE:    if (start)         state_nxt = ARMED;
                default:                    state_nxt = IDLE;
            endcase
        end
    end

    // The ARMED-state rise is the sequencer setup edge, so ptr only advances from SEND
    always_ff @(posedge oscclk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 7'd0;
            len <= 8'd0;
        end else if (abort) begin
            ptr <= 7'd0;
        end else if (start) begin
            ptr <= 7'd0;
            len <= clamp_len(bitcount);
        end else if ((state == SEND) && rise && !last) begin
            ptr <= ptr + 7'd1;
        end
    end

    always_ff @(posedge oscclk) begin
        if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        busy       = (state != IDLE);
        datadone   = ((state == SEND) && last) || (state == DONE);
        databitsrc = 1'b0;
        if (state != IDLE) databitsrc = mem[ptr[6:3]][3'd7 - ptr[2:0]];
    end

`ifdef TXDATA_OVERRUN_EN
    // arm wins over a coincident rise so a fresh reply always starts with a clean flag
    always_ff @(posedge oscclk or negedge reset_n) begin
        if (!reset_n)                                       overrun <= 1'b0;
        else if (arm)                                       overrun <= 1'b0;
        else if (rise && ((state == IDLE) || (state == DONE))) overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_tx_data_source.sv
// Randomized self-checking bench for tx_data_source against a byte-array reference model.
// Define TXDATA_OVERRUN_EN to also exercise the overrun flag.
module tb_tx_data_source;

    logic       oscclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] bitcount = 8'd0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       dataclk = 1'b0;
    logic       databitsrc;
    logic       datadone;
    logic       busy;
`ifdef TXDATA_OVERRUN_EN
    logic       overrun;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] mdl [16];

    always #5 oscclk = ~oscclk;

    tx_data_source dut (
        .oscclk     (oscclk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bitcount   (bitcount),
        .arm        (arm),
        .abort      (abort),
        .dataclk    (dataclk),
        .databitsrc (databitsrc),
        .datadone   (datadone),
        .busy       (busy)
`ifdef TXDATA_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    // Reference: bit k of the reply is bit (7 - k mod 8) of byte k/8
    function automatic logic mbit(input int k);
        logic [7:0] b;
        b = mdl[k / 8];
        return b[7 - (k % 8)];
    endfunction

    function automatic int mlen(input int bc);
        return (bc > 128) ? 128 : bc;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit takes_effect);
        @(negedge oscclk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge oscclk);
        wr_en = 1'b0;
        if (takes_effect) mdl[a] = d;
    endtask

    task automatic pulse_arm(input logic [7:0] bc);
        @(negedge oscclk);
        arm = 1'b1; bitcount = bc;
        @(negedge oscclk);
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge oscclk);
        abort = 1'b1;
        @(negedge oscclk);
        abort = 1'b0;
    endtask

    task automatic rise();
        @(negedge oscclk);
        dataclk = 1'b1;
        repeat (4) @(negedge oscclk);
        dataclk = 1'b0;
        repeat (4) @(negedge oscclk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge oscclk);
        checks++;
        if ({databitsrc, datadone, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: got bit/done/busy=%b%b%b want 000", databitsrc, datadone, busy);
        end
`ifdef TXDATA_OVERRUN_EN
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_overrun: got %b want 0", overrun);
        end
`endif
        reset_n = 1'b1;
        repeat (2) @(negedge oscclk);
    endtask

    task automatic test_a5_sequence();
        wr(4'd0, 8'hA5, 1'b1);
        pulse_arm(8'd8);
        checks++;
        if ({databitsrc, datadone, busy} !== {mbit(0), 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL a5_armed: got %b%b%b want %b01", databitsrc, datadone, busy, mbit(0));
        end
        for (int r = 1; r <= 9; r++) begin
            logic eb, ed;
            rise();
            eb = (r <= 8) ? mbit(r - 1) : mbit(7);
            ed = (r >= 8);
            checks++;
            if ({databitsrc, datadone, busy} !== {eb, ed, 1'b1}) begin
                failures++;
                $display("FAIL a5_rise%0d: got %b%b%b want %b%b1", r, databitsrc, datadone, busy, eb, ed);
            end
        end
        // Only DONE (not SEND) accepts a restart, which drops datadone
        pulse_arm(8'd8);
        checks++;
        if ({datadone, busy} !== 2'b01) begin
            failures++;
            $display("FAIL a5_done_rearm: got done/busy=%b%b want 01", datadone, busy);
        end
        pulse_abort();
    endtask

    task automatic test_latency();
        wr(4'd0, 8'h40, 1'b1);
        pulse_arm(8'd8);
        rise();
        @(negedge oscclk);
        dataclk = 1'b1;
        repeat (2) @(negedge oscclk);
        checks++;
        if (databitsrc !== mbit(0)) begin
            failures++;
            $display("FAIL latency_early: got %b want %b", databitsrc, mbit(0));
        end
        @(negedge oscclk);
        checks++;
        if (databitsrc !== mbit(1)) begin
            failures++;
            $display("FAIL latency_3cyc: got %b want %b", databitsrc, mbit(1));
        end
        repeat (2) @(negedge oscclk);
        dataclk = 1'b0;
        repeat (4) @(negedge oscclk);
        pulse_abort();
    endtask

    task automatic test_len1();
        wr(4'd0, 8'h80, 1'b1);
        pulse_arm(8'd1);
        checks++;
        if ({databitsrc, datadone, busy} !== 3'b101) begin
            failures++;
            $display("FAIL len1_armed: got %b%b%b want 101", databitsrc, datadone, busy);
        end
        rise();
        checks++;
        if ({databitsrc, datadone, busy} !== 3'b111) begin
            failures++;
            $display("FAIL len1_setup: got %b%b%b want 111", databitsrc, datadone, busy);
        end
        rise();
        pulse_arm(8'd8);
        checks++;
        if ({datadone, busy} !== 2'b01) begin
            failures++;
            $display("FAIL len1_done: got done/busy=%b%b want 01", datadone, busy);
        end
        pulse_abort();
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF, 1'b1);
        pulse_arm(8'd200);
        for (int r = 1; r <= 129; r++) begin
            logic ed;
            rise();
            ed = (r >= mlen(200));
            checks++;
            if ({databitsrc, datadone, busy} !== {1'b1, ed, 1'b1}) begin
                failures++;
                $display("FAIL clamp_rise%0d: got %b%b%b want 1%b1", r, databitsrc, datadone, busy, ed);
            end
        end
        pulse_arm(8'd8);
        checks++;
        if ({datadone, busy} !== 2'b01) begin
            failures++;
            $display("FAIL clamp_done: got done/busy=%b%b want 01", datadone, busy);
        end
        pulse_abort();
    endtask

    task automatic test_abort();
        @(negedge oscclk);
        arm = 1'b1; abort = 1'b1; bitcount = 8'd8;
        @(negedge oscclk);
        arm = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL arm_abort_same: got busy=%b want 0", busy);
        end
        pulse_arm(8'd0);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL arm_zero_len: got busy=%b want 0", busy);
        end
        wr(4'd0, 8'h5A, 1'b1);
        pulse_arm(8'd16);
        for (int r = 1; r <= 6; r++) rise();
        checks++;
        if ({databitsrc, datadone, busy} !== {mbit(5), 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort_ptr5_pre: got %b%b%b want %b01", databitsrc, datadone, busy, mbit(5));
        end
        pulse_abort();
        checks++;
        if ({databitsrc, datadone, busy} !== 3'b000) begin
            failures++;
            $display("FAIL abort_send: got %b%b%b want 000", databitsrc, datadone, busy);
        end
    endtask

    task automatic test_write_ignored();
        wr(4'd0, 8'h00, 1'b1);
        pulse_arm(8'd8);
        rise();
        wr(4'd0, 8'hFF, 1'b0);
        for (int r = 2; r <= 8; r++) begin
            rise();
            checks++;
            if ({databitsrc, datadone} !== {mbit(r - 1), r == 8}) begin
                failures++;
                $display("FAIL write_ignored_rise%0d: got bit/done=%b%b want %b%b",
                         r, databitsrc, datadone, mbit(r - 1), r == 8);
            end
        end
        pulse_abort();
    endtask

    task automatic test_arm_ignored();
        wr(4'd0, 8'($urandom), 1'b1);
        wr(4'd1, 8'($urandom), 1'b1);
        pulse_arm(8'd12);
        for (int r = 1; r <= 13; r++) begin
            logic eb, ed;
            if (r == 4) pulse_arm(8'd3);
            rise();
            eb = (r <= 12) ? mbit(r - 1) : mbit(11);
            ed = (r >= 12);
            checks++;
            if ({databitsrc, datadone, busy} !== {eb, ed, 1'b1}) begin
                failures++;
                $display("FAIL arm_in_send_rise%0d: got %b%b%b want %b%b1", r, databitsrc, datadone, busy, eb, ed);
            end
        end
        pulse_abort();
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int bc, l;
            for (int i = 0; i < 16; i++) wr(4'(i), 8'($urandom), 1'b1);
            bc = int'($urandom_range(1, 255));
            l = mlen(bc);
            pulse_arm(8'(bc));
            checks++;
            if ({databitsrc, datadone, busy} !== {mbit(0), 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL rand%0d_armed: got %b%b%b want %b01", it, databitsrc, datadone, busy, mbit(0));
            end
            for (int r = 1; r <= l + 1; r++) begin
                logic eb, ed;
                rise();
                eb = (r <= l) ? mbit(r - 1) : mbit(l - 1);
                ed = (r >= l);
                checks++;
                if ({databitsrc, datadone, busy} !== {eb, ed, 1'b1}) begin
                    failures++;
                    $display("FAIL rand%0d_len%0d_rise%0d: got %b%b%b want %b%b1",
                             it, l, r, databitsrc, datadone, busy, eb, ed);
                end
            end
            pulse_abort();
        end
    endtask

    task automatic test_reset_midsend();
        wr(4'd0, 8'hFF, 1'b1);
        pulse_arm(8'd8);
        for (int r = 1; r <= 3; r++) rise();
        @(posedge oscclk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({databitsrc, datadone, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_midsend: got %b%b%b want 000", databitsrc, datadone, busy);
        end
        repeat (2) @(negedge oscclk);
        reset_n = 1'b1;
        for (int r = 1; r <= 6; r++) rise();
        checks++;
        if ({databitsrc, datadone, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_abandon: got %b%b%b want 000", databitsrc, datadone, busy);
        end
    endtask

`ifdef TXDATA_OVERRUN_EN
    task automatic test_overrun();
        wr(4'd0, 8'hA5, 1'b1);
        pulse_arm(8'd8);
        for (int r = 1; r <= 9; r++) rise();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_normal: got %b want 0", overrun);
        end
        rise();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set_done: got %b want 1", overrun);
        end
        pulse_arm(8'd8);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear_arm: got %b want 0", overrun);
        end
        pulse_abort();
        rise();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set_idle: got %b want 1", overrun);
        end
        pulse_arm(8'd4);
        pulse_abort();
    endtask
`endif

    initial begin
        test_reset();
        test_a5_sequence();
        test_latency();
        test_len1();
        test_clamp();
        test_abort();
        test_write_ignored();
        test_arm_ignored();
        test_random();
`ifdef TXDATA_OVERRUN_EN
        test_overrun();
`endif
        test_reset_midsend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_data_source.md
TX_DATA_SOURCE -- requirements
Module: tx_data_source

Interface
REQ-001 The module SHALL have one clock, oscclk, and one asynchronous active-low reset, reset_n; no other clocks or resets.
REQ-002 oscclk  in  1  free-running system oscillator; all state on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 wr_en  in  1  payload byte write strobe.
REQ-005 wr_addr  in  4  payload byte index 0..15.
REQ-006 wr_data  in  8  payload byte value.
REQ-007 bitcount  in  8  reply length in bits; sampled on arm.
REQ-008 arm  in  1  single-cycle pulse that starts a reply.
REQ-009 abort  in  1  single-cycle pulse that returns the block to IDLE.
REQ-010 dataclk  in  1  bit clock from the TX sequencer, asynchronous to oscclk.
REQ-011 databitsrc  out  1  current data bit to the sequencer and CRC.
REQ-012 datadone  out  1  high while the last bit is presented and after it.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 overrun  out  1  sticky dataclk misuse flag; present only with TXDATA_OVERRUN_EN.

Function
REQ-015 The payload buffer SHALL be 16x8 bits, sent byte 0 first, MSB first; bit pointer ptr[6:0] selects byte ptr[6:3], bit 7-ptr[2:0].
REQ-016 Writes SHALL take effect only in IDLE; writes in any other state SHALL be ignored.
REQ-017 dataclk SHALL pass through a two-flop synchronizer; a rise SHALL be sync2 high with the previous sync2 low; databitsrc SHALL update 3 oscclk cycles after a dataclk rising edge.
REQ-018 dataclk high and low phases SHALL each last at least 3 oscclk periods; shorter phases have undefined results.
REQ-019 The states SHALL be IDLE, ARMED, SEND and DONE.
REQ-020 IDLE: arm with bitcount!=0 SHALL latch len=min(bitcount,128), set ptr=0, and go to ARMED; arm with bitcount==0 SHALL be ignored.
REQ-021 ARMED: the first dataclk rise is the sequencer setup edge and SHALL move the block to SEND with ptr=0.
REQ-022 SEND: on each dataclk rise, the block SHALL go to DONE if ptr==len-1, otherwise it SHALL increment ptr.
REQ-023 DONE: the block SHALL hold ptr and wait for arm or abort; arm SHALL restart as in IDLE.
REQ-024 databitsrc SHALL be buffer[ptr] in ARMED, SEND and DONE, and 0 in IDLE.
REQ-025 datadone SHALL be 1 in SEND when ptr==len-1 and 1 in DONE; it SHALL be 0 otherwise.
REQ-026 abort SHALL force IDLE with ptr=0 from any state; abort together with arm SHALL resolve to abort.
REQ-027 arm in ARMED or SEND SHALL be ignored.
REQ-028 A write and arm in the same IDLE cycle SHALL both take effect.
REQ-029 len=1 SHALL assert datadone immediately on entry to SEND.

Reset
REQ-030 While reset_n is low, the block SHALL be in IDLE with ptr=0, len=0 and the synchronizer flops cleared.
REQ-031 Outputs during reset SHALL be databitsrc=0, datadone=0, busy=0 and overrun=0.
REQ-032 Buffer contents SHALL be undefined after reset.
REQ-033 Reset asserted mid-reply SHALL abandon the reply immediately, with no further datadone.

Configuration
REQ-034 With TXDATA_OVERRUN_EN defined, a dataclk rise in IDLE or DONE SHALL set overrun, and arm SHALL clear it; arm and a rise in the same cycle SHALL clear it.
REQ-035 Without TXDATA_OVERRUN_EN, the overrun port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-036 Write byte0=0xA5, bitcount=8, arm, 9 dataclk rises -> databitsrc sequence 1,0,1,0,0,1,0,1; datadone rises after rise 8; state DONE after rise 9.
REQ-037 bitcount=1, byte0=0x80, arm, setup rise -> datadone=1 and databitsrc=1; next rise -> DONE.
REQ-038 bitcount=200, all bytes 0xFF, arm, 129 rises -> datadone asserts at ptr=127 (len clamped to 128).
REQ-039 arm+abort in the same cycle -> busy stays 0; abort during SEND at ptr=5 -> IDLE, databitsrc=0, datadone=0.
REQ-040 Write during SEND (byte0 0x00 -> 0xFF) -> buffer unchanged; reset_n low mid-SEND -> all outputs 0 asynchronously.
REQ-041 With TXDATA_OVERRUN_EN, a dataclk rise in DONE -> overrun=1; the next arm -> overrun=0.
